tone_decoder: RTL
=================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 SHALL have parameter HALF_FAST, default 100_000, meaning the key-pressed tone half-period in clk cycles.
REQ-002 SHALL have parameter HALF_SLOW, default 1_000_000, meaning the idle tone half-period in clk cycles.
REQ-003 SHALL have parameter TOL, default 1_000, meaning the allowed +/- deviation in cycles.
REQ-004 SHALL have parameter TIMEOUT, default 1_500_000, meaning the number of cycles without an edge before the lock is lost.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port tone_in, input, 1 bit: square-wave beep signal, asynchronous to clk.
REQ-008 SHALL have port tone_valid, output, 1 bit: high while a tone is locked.
REQ-009 SHALL have port tone_sel, output, 1 bit: locked class, 1 = fast, 0 = slow; meaningful only while tone_valid is high.
REQ-010 SHALL have port half_period, output, 32 bits: last measured edge-to-edge interval.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on an out-of-tolerance measurement.
REQ-012 SHALL have port lost, output, 1 bit: one-cycle pulse when LOCK is left by timeout.

Function
REQ-013 SHALL pass tone_in through a 2-flop synchronizer, then a third flop for edge detection; edge = XOR of flops 2 and 3, so both rising and falling edges count.
REQ-014 SHALL measure m = number of clk cycles between consecutive edge pulses, using a 32-bit counter cleared on each edge pulse and saturating at TIMEOUT.
REQ-015 SHALL classify m as FAST if |m-HALF_FAST| <= TOL, SLOW if |m-HALF_SLOW| <= TOL, and INVALID otherwise; boundary values at exactly +/-TOL are in class.
REQ-016 SHALL implement FSM states IDLE, ARMED, CAND and LOCK; reset state is IDLE.
REQ-017 SHALL, in IDLE, go to ARMED on an edge; no measurement is taken.
REQ-018 SHALL, in ARMED on an edge: valid class -> CAND with cand=class; INVALID -> stay in ARMED and pulse err.
REQ-019 SHALL, in CAND on an edge: class==cand -> LOCK; other valid class -> stay in CAND with cand=class; INVALID -> ARMED and pulse err.
REQ-020 SHALL, in LOCK on an edge: same class -> stay; other valid class -> CAND with the new cand; INVALID -> ARMED and pulse err.
REQ-021 SHALL leave any non-IDLE state for IDLE when the counter reaches TIMEOUT with no edge; lost pulses only if the state was LOCK.
REQ-022 SHALL give an edge pulse priority over timeout when both occur in the same cycle.
REQ-023 SHALL register every output: tone_valid = (state==LOCK); tone_sel = cand while in LOCK.
REQ-024 SHALL update half_period on every measured edge, whether or not the class is valid.
REQ-025 SHALL update outputs the cycle after the edge pulse; total latency from tone_in change to output is 4 clk cycles.
REQ-026 SHALL, when the class changes in LOCK, drop tone_valid immediately and re-assert it only after two consecutive matching measurements.

Reset
REQ-027 SHALL, while rst_n is low, immediately force state=IDLE, counter=0, synchronizer flops=0, tone_valid=0, tone_sel=0, half_period=0, err=0 and lost=0.
REQ-028 SHALL restart acquisition from IDLE when reset occurs mid-lock; 3 edges after release are needed to re-lock.

Structure
REQ-029 SHALL place the FSM state enum, the class enum (FAST, SLOW, INVALID) and the default parameter constants in shared package tone_pkg.
REQ-030 SHALL use one sub-module, sync_edge, containing the 2-flop synchronizer, the edge flop and the edge pulse output.
REQ-031 SHALL ensure, by elaboration-time check, that 2*TOL < HALF_SLOW-HALF_FAST and TIMEOUT > HALF_SLOW+TOL.

Verification (sim parameters HALF_FAST=10, HALF_SLOW=100, TOL=2, TIMEOUT=150)
REQ-032 SHALL cover: half-period 10 -> tone_valid=1, tone_sel=1 and half_period=10 four cycles after the 3rd edge.
REQ-033 SHALL cover: half-period 100, then switch to 10 -> tone_valid falls after the first 10-interval and re-locks with tone_sel=1 on the next edge.
REQ-034 SHALL cover: half-period 12 -> locks FAST; half-period 13 -> err pulse on every edge and tone_valid stays 0.
REQ-035 SHALL cover: stop toggling while locked -> tone_valid=0 and a single lost pulse 150 cycles after the last edge; an edge coinciding with cycle 150 keeps the lock.
REQ-036 SHALL cover: rst_n low for 1 cycle mid-lock -> all outputs 0 asynchronously; re-lock requires 3 edges.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: shared state/class types, default timing constants and period classifier.
package tone_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, CAND, LOCK} state_t;
    typedef enum logic [1:0] {FAST, SLOW, INVALID} class_t;

    localparam int HALF_FAST_DEF = 100_000;
    localparam int HALF_SLOW_DEF = 1_000_000;
    localparam int TOL_DEF       = 1_000;
    localparam int TIMEOUT_DEF   = 1_500_000;

    function automatic class_t classify(input logic [31:0] m, input int fast, input int slow, input int tol);
        longint v;
        v = longint'(m);
        return (v >= longint'(fast - tol) && v <= longint'(fast + tol)) ? FAST
             : (v >= longint'(slow - tol) && v <= longint'(slow + tol)) ? SLOW : INVALID;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer plus edge flop; pulse on either tone_in transition.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic tone_in,
    output logic pulse
);

    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else sr <= {sr[1:0], tone_in};

    assign pulse = sr[1] ^ sr[2];

endmodule

// File: rtl/tone_decoder.sv
// tone_decoder: measures tone_in half-periods and locks onto the fast or slow tone.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int HALF_FAST = HALF_FAST_DEF,
    parameter int HALF_SLOW = HALF_SLOW_DEF,
    parameter int TOL       = TOL_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tone_in,
    output logic        tone_valid,
    output logic        tone_sel,
    output logic [31:0] half_period,
    output logic        err,
    output logic        lost
);

    if (2 * TOL >= HALF_SLOW - HALF_FAST || TIMEOUT <= HALF_SLOW + TOL) begin : g_param_check
        $error("tone_decoder: tolerance windows overlap or TIMEOUT too short");
    end

    logic        pulse;
    logic        tout;
    logic        cand;
    logic        nc;
    logic        bad;
    logic [31:0] cnt;
    logic [31:0] m;
    class_t      cls;
    state_t      state;
    state_t      ns;

    sync_edge u_sync (.clk(clk), .rst_n(rst_n), .tone_in(tone_in), .pulse(pulse));

    // m counts the edge cycle itself, so edges N cycles apart measure N
    assign m    = cnt + 32'd1;
    assign cls  = classify(m, HALF_FAST, HALF_SLOW, TOL);
    assign tout = !pulse && cnt == 32'(TIMEOUT - 1);

    always_comb begin
        ns  = state;
        nc  = cand;
        bad = 1'b0;
        if (pulse) begin
            if (state == IDLE) ns = ARMED;
            else if (cls == INVALID) begin
                ns  = ARMED;
                bad = 1'b1;
            end else begin
                nc = cls == FAST;
                ns = (state != ARMED && nc == cand) ? LOCK : CAND;
            end
        end else if (tout) ns = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= IDLE;
            cand        <= 1'b0;
            cnt         <= '0;
            tone_valid  <= 1'b0;
            tone_sel    <= 1'b0;
            half_period <= '0;
            err         <= 1'b0;
            lost        <= 1'b0;
        end else begin
            state      <= ns;
            cand       <= nc;
            cnt        <= pulse ? '0 : (cnt == 32'(TIMEOUT) ? cnt : cnt + 32'd1);
            tone_valid <= ns == LOCK;
            tone_sel   <= ns == LOCK && nc;
            err        <= bad;
            lost       <= tout && state == LOCK;
            if (pulse && state != IDLE) half_period <= m;
        end

endmodule
